// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU control path.
// Contents: ISA opcode encodings, accumulator-source and ALU-op encodings,
// controller state enum and default parameter values.
package cpu_pkg;

  localparam int OPW_DEF      = 4;   // opcode width, fixed by the ISA
  localparam int WAIT_MAX_DEF = 15;  // memory wait budget in cycles
  localparam int CNT_W_DEF    = 16;  // retired-instruction counter width

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_IMM = 2'd2
  } acc_src_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2
  } alu_op_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEMRD  = 3'd2,
    S_MEMWR  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control bus between the CPU controller and the datapath/memory side.
// master: the controller (drives strobes/pulses/status, receives opcode,
//         zero_flag and mem_ready).
// slave : the datapath/memory side (mirror directions).
interface cpu_control_fsm_if
  import cpu_pkg::*;
#(
  parameter int OPW   = OPW_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [OPW-1:0]   opcode;
  logic             zero_flag;
  logic             mem_ready;
  logic             mem_rd;
  logic             mem_wr;
  logic             addr_sel;
  logic             load_ir;
  logic             pc_inc;
  logic             pc_load;
  logic             acc_load;
  logic [1:0]       acc_src;
  logic [1:0]       alu_op;
  logic             halted;
  logic             error;
  logic [CNT_W-1:0] retired_count;

  modport master (
    input  opcode, zero_flag, mem_ready,
    output mem_rd, mem_wr, addr_sel, load_ir, pc_inc, pc_load,
           acc_load, acc_src, alu_op, halted, error, retired_count
  );

  modport slave (
    output opcode, zero_flag, mem_ready,
    input  mem_rd, mem_wr, addr_sel, load_ir, pc_inc, pc_load,
           acc_load, acc_src, alu_op, halted, error, retired_count
  );

endinterface

// File: rtl/cpu_control_fsm_mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory access has waited for mem_ready.
// Ports: clock, reset (async, active-high), i_active (a strobe is out this
// cycle), i_ready (mem_ready), o_timeout (this is the WAIT_MAX-th waiting
// cycle and memory still has not answered).
// The count returns to zero whenever no access is pending or an access
// completes, which gives every FETCH/MEMRD/MEMWR entry a fresh budget.
module mem_wait_timer
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int         W     = $clog2(WAIT_MAX + 1);
  localparam logic [W-1:0] LIMIT = W'(WAIT_MAX - 1);

  logic [W-1:0] r_count;

  // A ready in the last allowed cycle still wins over the timeout.
  assign o_timeout = i_active && !i_ready && (r_count == LIMIT);

  // Wait counter: cleared when idle, on completion or on timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= {W{1'b0}};
    end else if (!i_active || i_ready || o_timeout) begin
      r_count <= {W{1'b0}};
    end else begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute sequencer for the 8-bit
// accumulator CPU.
// Ports: clock, reset (async, active-high), step (only with SINGLE_STEP_EN),
// bus (cpu_control_fsm_if.master: opcode/zero_flag/mem_ready in; memory
// strobes, IR/PC/ACC controls, alu_op, halted, error, retired_count out).
// Optional feature macro: SINGLE_STEP_EN -- FETCH waits idle until step is
// seen high, then one instruction executes.
// Strobes and pulses are decoded combinationally from state + inputs and are
// forced low while reset is asserted so an interrupted access ends at once.
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset,
`ifdef SINGLE_STEP_EN
  input  logic step,
`endif
  cpu_control_fsm_if.master bus
);

  state_t           r_state, w_next;
  logic             r_error;
  logic [CNT_W-1:0] r_retired;
  logic             w_go, w_active, w_timeout, w_retire, w_set_error;
  logic             w_mem_rd, w_mem_wr, w_addr_sel, w_load_ir;
  logic             w_pc_inc, w_pc_load, w_acc_load;
  acc_src_t         w_acc_src;
  alu_op_t          w_alu_op;

`ifdef SINGLE_STEP_EN
  logic r_armed;

  // Step arming: latched only while idle in FETCH, released when that fetch ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else if ((r_state == S_FETCH) && !r_armed && step) begin
      r_armed <= 1'b1;
    end else if ((r_state == S_FETCH) && r_armed && (bus.mem_ready || w_timeout)) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= r_armed;
    end
  end

  assign w_go = r_armed;
`else
  assign w_go = 1'b1;
`endif

  // A memory access is pending in these cycles; drives the wait timer.
  assign w_active = !reset && (((r_state == S_FETCH) && w_go) ||
                               (r_state == S_MEMRD) || (r_state == S_MEMWR));

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clock     (clock),
    .reset     (reset),
    .i_active  (w_active),
    .i_ready   (bus.mem_ready),
    .o_timeout (w_timeout)
  );

  // State, sticky error and retired-instruction counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_error   <= 1'b0;
      r_retired <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next;
      r_error <= r_error | w_set_error;
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end else begin
        r_retired <= r_retired;
      end
    end
  end

  // Next state and per-cycle strobes/pulses.
  always_comb begin
    w_next      = r_state;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_addr_sel  = 1'b0;
    w_load_ir   = 1'b0;
    w_pc_inc    = 1'b0;
    w_pc_load   = 1'b0;
    w_acc_load  = 1'b0;
    w_acc_src   = SRC_ALU;
    w_alu_op    = ALU_PASS;
    w_retire    = 1'b0;
    w_set_error = 1'b0;
    if (reset) begin
      w_next = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_go) begin
            w_mem_rd = 1'b1;
            if (bus.mem_ready) begin
              w_load_ir = 1'b1;
              w_pc_inc  = 1'b1;
              w_next    = S_DECODE;
            end else if (w_timeout) begin
              w_set_error = 1'b1;
              w_next      = S_HALT;
            end else begin
              w_next = S_FETCH;
            end
          end else begin
            w_next = S_FETCH;
          end
        end
        S_DECODE: begin
          case (bus.opcode)
            OP_NOP: begin
              w_retire = 1'b1;
              w_next   = S_FETCH;
            end
            OP_LDI: begin
              w_acc_load = 1'b1;
              w_acc_src  = SRC_IMM;
              w_retire   = 1'b1;
              w_next     = S_FETCH;
            end
            OP_JMP: begin
              w_pc_load = 1'b1;
              w_retire  = 1'b1;
              w_next    = S_FETCH;
            end
            OP_JZ: begin
              w_pc_load = bus.zero_flag;
              w_retire  = 1'b1;
              w_next    = S_FETCH;
            end
            OP_HLT: begin
              w_retire = 1'b1;
              w_next   = S_HALT;
            end
            OP_LDA, OP_ADD, OP_SUB: begin
              w_next = S_MEMRD;
            end
            OP_STA: begin
              w_next = S_MEMWR;
            end
            default: begin
              w_set_error = 1'b1;
              w_next      = S_HALT;
            end
          endcase
        end
        S_MEMRD: begin
          w_mem_rd   = 1'b1;
          w_addr_sel = 1'b1;
          if (bus.mem_ready) begin
            w_acc_load = 1'b1;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
            // Opcode is still held in the IR during the operand read.
            case (bus.opcode)
              OP_ADD: begin
                w_acc_src = SRC_ALU;
                w_alu_op  = ALU_ADD;
              end
              OP_SUB: begin
                w_acc_src = SRC_ALU;
                w_alu_op  = ALU_SUB;
              end
              default: begin
                w_acc_src = SRC_MEM;
                w_alu_op  = ALU_PASS;
              end
            endcase
          end else if (w_timeout) begin
            w_set_error = 1'b1;
            w_next      = S_HALT;
          end else begin
            w_next = S_MEMRD;
          end
        end
        S_MEMWR: begin
          w_mem_wr   = 1'b1;
          w_addr_sel = 1'b1;
          if (bus.mem_ready) begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else if (w_timeout) begin
            w_set_error = 1'b1;
            w_next      = S_HALT;
          end else begin
            w_next = S_MEMWR;
          end
        end
        S_HALT: begin
          w_next = S_HALT;
        end
        default: begin
          w_set_error = 1'b1;
          w_next      = S_HALT;
        end
      endcase
    end
  end

  assign bus.mem_rd        = w_mem_rd;
  assign bus.mem_wr        = w_mem_wr;
  assign bus.addr_sel      = w_addr_sel;
  assign bus.load_ir       = w_load_ir;
  assign bus.pc_inc        = w_pc_inc;
  assign bus.pc_load       = w_pc_load;
  assign bus.acc_load      = w_acc_load;
  assign bus.acc_src       = w_acc_src;
  assign bus.alu_op        = w_alu_op;
  assign bus.halted        = (r_state == S_HALT);
  assign bus.error         = r_error;
  assign bus.retired_count = r_retired;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm. Expected behaviour is built per
// instruction as a list of cycles (memory accesses with a chosen number of
// wait cycles, a decode cycle, halt cycles) and replayed against the DUT.
module tb_cpu_control_fsm;
  import cpu_pkg::*;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;
    logic       load_ir;
    logic       pc_inc;
    logic       pc_load;
    logic       acc_load;
    logic [1:0] acc_src;
    logic [1:0] alu_op;
    logic       halted;
    logic       error;
  } obs_t;

  typedef struct {
    logic       rdy;
    logic       zf;
    logic [3:0] op;
    obs_t       exp;
    bit         ret;
  } cyc_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  cpu_control_fsm_if #(.OPW(4), .CNT_W(16)) bus ();
`ifdef SINGLE_STEP_EN
  logic step = 1'b1;
`endif

  cpu_control_fsm #(.WAIT_MAX(15), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
`ifdef SINGLE_STEP_EN
    .step  (step),
`endif
    .bus   (bus)
  );

  always #5 clock = ~clock;

  cyc_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] model_cnt = 16'd0;

  function automatic obs_t sample();
    obs_t o;
    o.mem_rd   = bus.mem_rd;
    o.mem_wr   = bus.mem_wr;
    o.addr_sel = bus.addr_sel;
    o.load_ir  = bus.load_ir;
    o.pc_inc   = bus.pc_inc;
    o.pc_load  = bus.pc_load;
    o.acc_load = bus.acc_load;
    o.acc_src  = bus.acc_src;
    o.alu_op   = bus.alu_op;
    o.halted   = bus.halted;
    o.error    = bus.error;
    return o;
  endfunction

  task automatic check_now(input string tag, input obs_t e);
    obs_t a;
    a = sample();
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s outputs got=%h expected=%h", tag, a, e);
    end
    checks++;
    assert (bus.retired_count === model_cnt) else begin
      errors++;
      $error("FAIL %s retired got=%0d expected=%0d", tag, bus.retired_count, model_cnt);
    end
  endtask

  task automatic push(input logic rdy, input logic zf, input logic [3:0] op,
                      input obs_t e, input bit ret);
    cyc_t c;
    c.rdy = rdy; c.zf = zf; c.op = op; c.exp = e; c.ret = ret;
    q.push_back(c);
  endtask

  // One memory access: w cycles without ready, then the completing cycle.
  task automatic add_access(input int w, input bit from_ir, input bit wr,
                            input obs_t done, input logic [3:0] op,
                            input logic zf, input bit ret);
    obs_t s, e;
    s = '0;
    s.mem_rd = !wr; s.mem_wr = wr; s.addr_sel = from_ir;
    for (int i = 0; i < w; i++) push(1'b0, zf, op, s, 1'b0);
    e = done;
    e.mem_rd = !wr; e.mem_wr = wr; e.addr_sel = from_ir;
    push(1'b1, zf, op, e, ret);
  endtask

  task automatic add_instr(input logic [3:0] op, input logic zf, input int wf, input int wm);
    obs_t f, d, m;
    logic r;
    f = '0; d = '0; m = '0;
    f.load_ir = 1'b1; f.pc_inc = 1'b1;
    r = 1'($urandom_range(0, 1));
    add_access(wf, 1'b0, 1'b0, f, op, zf, 1'b0);
    case (op)
      4'h0: push(r, zf, op, d, 1'b1);
      4'h5: begin d.acc_load = 1'b1; d.acc_src = 2'd2; push(r, zf, op, d, 1'b1); end
      4'h6: begin d.pc_load = 1'b1; push(r, zf, op, d, 1'b1); end
      4'h7: begin d.pc_load = zf; push(r, zf, op, d, 1'b1); end
      4'hF: push(r, zf, op, d, 1'b1);
      4'h1, 4'h2, 4'h3: begin
        push(r, zf, op, d, 1'b0);
        m.acc_load = 1'b1;
        m.acc_src  = (op == 4'h1) ? 2'd1 : 2'd0;
        m.alu_op   = (op == 4'h2) ? 2'd1 : ((op == 4'h3) ? 2'd2 : 2'd0);
        add_access(wm, 1'b1, 1'b0, m, op, zf, 1'b1);
      end
      4'h4: begin
        push(r, zf, op, d, 1'b0);
        add_access(wm, 1'b1, 1'b1, m, op, zf, 1'b1);
      end
      default: push(r, zf, op, d, 1'b0);  // illegal: no strobes, not retired
    endcase
  endtask

  task automatic add_halt(input int n, input logic err);
    obs_t h;
    h = '0; h.halted = 1'b1; h.error = err;
    for (int i = 0; i < n; i++) push(1'($urandom_range(0, 1)), 1'b0, 4'h0, h, 1'b0);
  endtask

  task automatic run_q(input string tag);
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.mem_ready = c.rdy;
      bus.zero_flag = c.zf;
      bus.opcode    = c.op;
      @(negedge clock);
      check_now(tag, c.exp);
      @(posedge clock); #1;
      if (c.ret) model_cnt = model_cnt + 16'd1;
    end
  endtask

  task automatic do_reset(input string tag);
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    model_cnt = 16'd0;
    @(negedge clock);
    check_now(tag, obs_t'(0));
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    obs_t s;
    bus.opcode = 4'h0; bus.zero_flag = 1'b0; bus.mem_ready = 1'b0;
    do_reset("reset");

    add_instr(4'h5, 1'b0, 0, 0);  run_q("ldi");
    add_instr(4'h2, 1'b0, 0, 4);  run_q("add_wait4");
    add_instr(4'h7, 1'b0, 0, 0);  run_q("jz_0");
    add_instr(4'h7, 1'b1, 0, 0);  run_q("jz_1");

    for (int i = 0; i < 40; i++) begin
      add_instr(4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 6), $urandom_range(0, 6));
    end
    run_q("random");

    add_instr(4'h1, 1'b0, 0, 14);  run_q("lda_wait14");
    add_instr(4'h4, 1'b0, 14, 3);  run_q("sta_fetch14");
    add_instr(4'h3, 1'b1, 2, 0);   run_q("sub");

    add_instr(4'hF, 1'b0, 1, 0);
    add_halt(4, 1'b0);
    run_q("hlt");

    do_reset("reset_after_hlt");
    add_instr(4'hA, 1'b0, 0, 0);
    add_halt(3, 1'b1);
    run_q("illegal");
    do_reset("reset_after_illegal");
    add_instr(4'h0, 1'b0, 0, 0);  run_q("nop_after_reset");

    // Abandon a store two cycles into its wait.
    add_instr(4'h5, 1'b0, 0, 0);
    s = '0; s.load_ir = 1'b1; s.pc_inc = 1'b1;
    add_access(0, 1'b0, 1'b0, s, 4'h4, 1'b0, 1'b0);
    push(1'b0, 1'b0, 4'h4, obs_t'(0), 1'b0);
    s = '0; s.mem_wr = 1'b1; s.addr_sel = 1'b1;
    push(1'b0, 1'b0, 4'h4, s, 1'b0);
    push(1'b0, 1'b0, 4'h4, s, 1'b0);
    run_q("sta_before_reset");
    do_reset("reset_mid_memwr");
    add_instr(4'h0, 1'b0, 0, 0);  run_q("fetch_after_reset");

    // Fetch that memory never answers.
    s = '0; s.mem_rd = 1'b1;
    for (int i = 0; i < 15; i++) push(1'b0, 1'b0, 4'h0, s, 1'b0);
    add_halt(4, 1'b1);
    run_q("fetch_timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
